// File: rtl/rst_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : rst_seq_ctrl_if
// Brief  : Request/acknowledge inputs and reset/status outputs of rst_seq_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
interface rst_seq_ctrl_if;
  logic       soft_rst_req_i;
  logic       wdog_rst_req_i;
  logic       halt_ack_i;
  logic       rst_rom_o;
  logic       rst_ram_o;
  logic       rst_cpu_o;
  logic       halt_req_o;
  logic       sys_ready_o;
  logic [1:0] rst_cause_o;
  logic       tmo_flag_o;

  modport master (
    output soft_rst_req_i, wdog_rst_req_i, halt_ack_i,
    input  rst_rom_o, rst_ram_o, rst_cpu_o, halt_req_o, sys_ready_o,
    input  rst_cause_o, tmo_flag_o
  );

  modport slave (
    input  soft_rst_req_i, wdog_rst_req_i, halt_ack_i,
    output rst_rom_o, rst_ram_o, rst_cpu_o, halt_req_o, sys_ready_o,
    output rst_cause_o, tmo_flag_o
  );
endinterface
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : rst_seq_ctrl
// Brief  : Staged ROM/RAM/CPU reset release with halt-drained warm resets.
// Rev    : 1.0  initial release
// ============================================================================
module rst_seq_ctrl #(
  parameter int HOLD_CYC  = 16,
  parameter int STAGE_CYC = 4,
  parameter int DRAIN_TMO = 32
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  rst_seq_ctrl_if.slave bus
);

  localparam logic [2:0] S_HOLD    = 3'd0;
  localparam logic [2:0] S_REL_ROM = 3'd1;
  localparam logic [2:0] S_REL_RAM = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] STAGE_LAST = 8'(STAGE_CYC - 1);
  localparam logic [7:0] TMO_LAST   = 8'(DRAIN_TMO - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       rom_rst;
  logic       ram_rst;
  logic       cpu_rst;
  logic       halt_req;
  logic       sys_ready;
  logic [1:0] rst_cause;
  logic       tmo_flag;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_HOLD;
      cnt       <= 8'd0;
      rom_rst   <= 1'b1;
      ram_rst   <= 1'b1;
      cpu_rst   <= 1'b1;
      halt_req  <= 1'b0;
      sys_ready <= 1'b0;
      rst_cause <= 2'b00;
      tmo_flag  <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state   <= S_REL_ROM;
            cnt     <= 8'd0;
            rom_rst <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_REL_ROM: begin
          if (cnt == STAGE_LAST) begin
            state   <= S_REL_RAM;
            cnt     <= 8'd0;
            ram_rst <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_REL_RAM: begin
          if (cnt == STAGE_LAST) begin
            state     <= S_RUN;
            cnt       <= 8'd0;
            cpu_rst   <= 1'b0;
            sys_ready <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RUN: begin
          // Watchdog outranks software when both are seen together.
          if (bus.soft_rst_req_i || bus.wdog_rst_req_i) begin
            state     <= S_DRAIN;
            cnt       <= 8'd0;
            halt_req  <= 1'b1;
            sys_ready <= 1'b0;
            rst_cause <= bus.wdog_rst_req_i ? 2'b10 : 2'b01;
          end
        end
        S_DRAIN: begin
          if (bus.halt_ack_i || (cnt == TMO_LAST)) begin
            state    <= S_HOLD;
            cnt      <= 8'd0;
            rom_rst  <= 1'b1;
            ram_rst  <= 1'b1;
            cpu_rst  <= 1'b1;
            halt_req <= 1'b0;
            // A late ack landing on the timeout cycle still counts as a clean halt.
            if (!bus.halt_ack_i) begin
              tmo_flag <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state     <= S_HOLD;
          cnt       <= 8'd0;
          rom_rst   <= 1'b1;
          ram_rst   <= 1'b1;
          cpu_rst   <= 1'b1;
          halt_req  <= 1'b0;
          sys_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_rom_o   = rom_rst;
  assign bus.rst_ram_o   = ram_rst;
  assign bus.rst_cpu_o   = cpu_rst;
  assign bus.halt_req_o  = halt_req;
  assign bus.sys_ready_o = sys_ready;
  assign bus.rst_cause_o = rst_cause;
  assign bus.tmo_flag_o  = tmo_flag;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_rst_seq_ctrl
// Brief  : Directed and random stimulus against a timestamp-based reference.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rst_seq_ctrl;

  localparam int H = 16;
  localparam int S = 4;
  localparam int T = 32;

  logic clk_i;
  logic rst_i;
  rst_seq_ctrl_if ifc ();

  rst_seq_ctrl #(.HOLD_CYC(H), .STAGE_CYC(S), .DRAIN_TMO(T)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (ifc.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: edges since reset deassertion, and the edge at which the
  // current phase (release sequence or drain) began.
  int         e;
  int         start;
  bit         in_drain;
  logic [1:0] m_cause;
  logic       m_tmo;

  task automatic model_reset();
    e = 0; start = 0; in_drain = 0; m_cause = 2'b00; m_tmo = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic w, input logic a);
    int p;
    p = e - start;
    e++;
    if (in_drain) begin
      if (a || p == T - 1) begin
        if (!a) m_tmo = 1'b1;
        in_drain = 0;
        start = e;
      end
    end else if (p >= H + 2 * S && (s || w)) begin
      in_drain = 1;
      start = e;
      m_cause = w ? 2'b10 : 2'b01;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  task automatic check_all();
    int age;
    logic x_rom, x_ram, x_cpu, x_halt, x_rdy;
    age = e - start;
    if (in_drain) begin
      x_rom = 0; x_ram = 0; x_cpu = 0; x_halt = 1; x_rdy = 0;
    end else begin
      x_rom  = (age < H);
      x_ram  = (age < H + S);
      x_cpu  = (age < H + 2 * S);
      x_halt = 0;
      x_rdy  = !x_cpu;
    end
    chk("rst_rom",   {7'd0, ifc.rst_rom_o},   {7'd0, x_rom});
    chk("rst_ram",   {7'd0, ifc.rst_ram_o},   {7'd0, x_ram});
    chk("rst_cpu",   {7'd0, ifc.rst_cpu_o},   {7'd0, x_cpu});
    chk("halt_req",  {7'd0, ifc.halt_req_o},  {7'd0, x_halt});
    chk("sys_ready", {7'd0, ifc.sys_ready_o}, {7'd0, x_rdy});
    chk("rst_cause", {6'd0, ifc.rst_cause_o}, {6'd0, m_cause});
    chk("tmo_flag",  {7'd0, ifc.tmo_flag_o},  {7'd0, m_tmo});
  endtask

  // Called at a falling edge; drives inputs, takes one rising edge, checks.
  task automatic cycle(input logic s, input logic w, input logic a);
    ifc.soft_rst_req_i = s;
    ifc.wdog_rst_req_i = w;
    ifc.halt_ack_i     = a;
    @(posedge clk_i);
    model_edge(s, w, a);
    #1;
    check_all();
    @(negedge clk_i);
  endtask

  task automatic drain_with_ack(input int d);
    int k;
    for (k = 0; k < 100 && in_drain; k++) cycle(1'b0, 1'b0, (e - start) == d);
    n_assert++;
    assert (!in_drain) else begin
      n_fail++;
      $error("FAIL drain_bound: observed=still_draining expected=drain_done");
    end
  endtask

  task automatic run_to_ready();
    int k;
    for (k = 0; k < 100 && (in_drain || (e - start) < H + 2 * S); k++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  // Asserts rst_i between clock edges and checks outputs before any edge.
  task automatic reset_pulse();
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk_i);
    check_all();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    ifc.soft_rst_req_i = 1'b0;
    ifc.wdog_rst_req_i = 1'b0;
    ifc.halt_ack_i     = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Power-on release; stray acks outside DRAIN must do nothing.
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, i[0]);

    // Soft reset, ack three cycles into the drain.
    cycle(1'b1, 1'b0, 1'b0);
    drain_with_ack(3);
    run_to_ready();

    // Simultaneous requests: watchdog wins.
    cycle(1'b1, 1'b1, 1'b0);
    drain_with_ack(5);
    run_to_ready();

    // Drain timeout, flag survives the re-release.
    cycle(1'b0, 1'b1, 1'b0);
    drain_with_ack(255);
    run_to_ready();

    // Reset during REL_RAM.
    cycle(1'b1, 1'b0, 1'b0);
    drain_with_ack(1);
    while ((e - start) < H + S + 2) cycle(1'b0, 1'b0, 1'b0);
    reset_pulse();
    run_to_ready();

    // Ack coincident with the final timeout cycle.
    cycle(1'b1, 1'b0, 1'b0);
    drain_with_ack(T - 1);
    run_to_ready();

    // Request held high: ignored outside RUN, retriggers on reaching RUN.
    for (int i = 0; i < 80; i++) cycle(1'b1, 1'b0, in_drain && (e - start) == 2);
    drain_with_ack(2);
    run_to_ready();

    // Reset mid-DRAIN.
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
    reset_pulse();
    run_to_ready();

    // Random traffic.
    for (int i = 0; i < 700; i++) begin
      logic rs, rw, ra;
      rs = ($urandom % 16) == 0;
      rw = ($urandom % 20) == 0;
      ra = in_drain ? (($urandom % 12) == 0) : (($urandom % 3) == 0);
      cycle(rs, rw, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter HOLD_CYC, default 16, meaning cycles all domains stay in reset after a sequence (re)starts; legal range 2..255.
REQ-002 Parameter STAGE_CYC, default 4, meaning cycles between successive domain releases; legal range 2..255.
REQ-003 Parameter DRAIN_TMO, default 32, meaning maximum cycles spent waiting for halt_ack_i; legal range 2..255.
REQ-004 Port clk_i, input, 1, meaning system clock; every register is clocked on its rising edge.
REQ-005 Port rst_i, input, 1, meaning global reset, asynchronous and active-high, driven from the debounced SCU reset.
REQ-006 Port soft_rst_req_i, input, 1, meaning level software reset request.
REQ-007 Port wdog_rst_req_i, input, 1, meaning level watchdog reset request.
REQ-008 Port halt_ack_i, input, 1, meaning CPU confirms it is halted at an instruction boundary.
REQ-009 Port rst_rom_o, output, 1, meaning ROM-domain reset, active-high.
REQ-010 Port rst_ram_o, output, 1, meaning RAM-domain reset, active-high.
REQ-011 Port rst_cpu_o, output, 1, meaning CPU-domain reset, active-high.
REQ-012 Port halt_req_o, output, 1, meaning request for the CPU to halt before a warm reset.
REQ-013 Port sys_ready_o, output, 1, meaning all domains are released and the system is running.
REQ-014 Port rst_cause_o, output, 2, meaning last reset cause: 00 power-on, 01 soft, 10 watchdog.
REQ-015 Port tmo_flag_o, output, 1, meaning sticky flag set when a drain ends by timeout.

Function
REQ-016 FSM states SHALL be HOLD, REL_ROM, REL_RAM, RUN and DRAIN, with a single shared cycle counter cnt, 8 bits wide, that clears on every state change.
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-018 HOLD: cnt increments each cycle; at cnt==HOLD_CYC-1 the FSM goes to REL_ROM and rst_rom_o deasserts on the same edge.
REQ-019 REL_ROM: at cnt==STAGE_CYC-1 the FSM goes to REL_RAM and rst_ram_o deasserts on the same edge.
REQ-020 REL_RAM: at cnt==STAGE_CYC-1 the FSM goes to RUN; on the same edge rst_cpu_o deasserts and sys_ready_o asserts.
REQ-021 The release order SHALL be ROM, then RAM, then CPU; assertion SHALL always hit all three domains on the same edge.
REQ-022 RUN: when either request is sampled high, the FSM goes to DRAIN.
REQ-023 On entry to DRAIN, halt_req_o goes to 1, sys_ready_o goes to 0, and rst_cause_o is loaded.
REQ-024 If both requests are sampled high together, watchdog has priority and rst_cause_o loads 10.
REQ-025 DRAIN: cnt increments each cycle; the drain ends on halt_ack_i==1 or at cnt==DRAIN_TMO-1, whichever comes first.
REQ-026 When the drain ends, on the next edge all three resets assert, halt_req_o clears, the FSM goes to HOLD and cnt clears.
REQ-027 If the drain ends by timeout without halt_ack_i, tmo_flag_o SHALL set; if halt_ack_i and the timeout occur in the same cycle, the ack wins and the flag stays 0.
REQ-028 Requests received in HOLD, REL_ROM, REL_RAM or DRAIN SHALL be ignored, not queued; requests still high when RUN is reached SHALL trigger a new drain.
REQ-029 halt_ack_i received outside DRAIN SHALL be ignored.
REQ-030 rst_cause_o SHALL hold its value through HOLD and the release stages until the next DRAIN entry or rst_i.
REQ-031 tmo_flag_o is sticky: only rst_i SHALL clear it.

Reset
REQ-032 While rst_i==1, asynchronously: state=HOLD, cnt=0, rst_rom_o=rst_ram_o=rst_cpu_o=1, halt_req_o=0, sys_ready_o=0, rst_cause_o=00, tmo_flag_o=0.
REQ-033 rst_i asserted in any state, including mid-DRAIN or mid-release, SHALL abort immediately to the REQ-032 values.
REQ-034 After rst_i deasserts, with default parameters, the releases occur on rising edges counted from deassertion as follows: rst_rom_o at edge 16, rst_ram_o at edge 20, rst_cpu_o and sys_ready_o at edge 24.

Verification
REQ-035 Power-on with defaults: release rst_i -> rst_rom_o falls at edge 16, rst_ram_o at edge 20, rst_cpu_o at edge 24, rst_cause_o=00.
REQ-036 Soft reset in RUN: soft_rst_req_i pulsed 1 cycle, halt_ack_i returned 3 cycles after halt_req_o -> all resets high 1 edge after the ack, full 16/4/4 re-release follows, rst_cause_o=01, tmo_flag_o=0.
REQ-037 Simultaneous requests: soft and wdog both high for 1 cycle in RUN -> rst_cause_o=10.
REQ-038 Drain timeout: wdog request with halt_ack_i held 0 -> resets assert 32 edges after DRAIN entry, tmo_flag_o=1, and the flag survives the next re-release.
REQ-039 Ack and timeout in the same cycle: halt_ack_i rises exactly when cnt==31 -> tmo_flag_o stays 0.
REQ-040 Reset mid-operation: rst_i pulsed during REL_RAM and again during DRAIN -> all outputs return to REQ-032 values with no clock edge, and the sequence restarts from edge 0.
